// File: rtl/ks_pkg.sv
// Shared constants and types for the pipelined Kogge-Stone add/subtract unit.
// Prefix spans, stage split and the per-stage propagate/generate bundle.
package ks_pkg;

    localparam int unsigned KS_WIDTH  = 28;
    localparam int unsigned KS_LEVELS = 5;

    localparam int unsigned KS_SPAN [KS_LEVELS] = '{1, 2, 4, 8, 16};

    // Prefix levels evaluated in each pipeline stage
    localparam int unsigned KS_S1_LEVELS = 2;
    localparam int unsigned KS_S2_LEVELS = 2;
    localparam int unsigned KS_S3_LEVELS = 1;

    typedef struct packed {
        logic [KS_WIDTH-1:0] g;
        logic [KS_WIDTH-1:0] p;
        logic [KS_WIDTH-1:0] p0;
        logic                cin;
        logic                valid;
    } ks_pg_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level of a given span.
// The bit just below the span folds in the carry-in, lower bits pass through.
module ks_prefix_level #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned SPAN  = 1
) (
    input  logic [WIDTH-1:0] G_IN,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             CIN,
    output logic [WIDTH-1:0] G_OUT,
    output logic [WIDTH-1:0] P_OUT
);

    always_comb begin
        G_OUT = G_IN;
        P_OUT = P_IN;
        for (int unsigned i = SPAN; i < WIDTH; i++) begin
            G_OUT[i] = G_IN[i] | (P_IN[i] & G_IN[i-SPAN]);
            P_OUT[i] = P_IN[i] & P_IN[i-SPAN];
        end
        // This group now reaches bit 0, so its generate becomes the final carry
        G_OUT[SPAN-1] = G_IN[SPAN-1] | (P_IN[SPAN-1] & CIN);
    end

endmodule

// File: rtl/ks28_pipe_addsub.sv
// Three-stage pipelined Kogge-Stone add/subtract with valid/ready flow control.
// Prefix levels 1,2 | 4,8 | 16 + sum, flags registered at the output.
module ks28_pipe_addsub
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH = KS_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int unsigned S2_FIRST = KS_S1_LEVELS;
    localparam int unsigned S3_FIRST = KS_S1_LEVELS + KS_S2_LEVELS;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             cin;
        logic             valid;
    } stage_t;

    stage_t s1;
    stage_t s2;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] lv_gi [KS_LEVELS];
    logic [WIDTH-1:0] lv_pi [KS_LEVELS];
    logic [WIDTH-1:0] lv_go [KS_LEVELS];
    logic [WIDTH-1:0] lv_po [KS_LEVELS];
    logic             lv_ci [KS_LEVELS];

    logic             adv1;
    logic             adv2;
    logic             adv3;

    logic [WIDTH-1:0] gpre;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    assign bx = B ^ {WIDTH{SUB}};

    // Each level reads either the previous level or the register that cuts in front of it
    for (genvar l = 0; l < KS_LEVELS; l++) begin : g_level
        if (l == 0) begin : g_src_in
            assign lv_gi[l] = A & bx;
            assign lv_pi[l] = A ^ bx;
            assign lv_ci[l] = SUB;
        end else if (l == S2_FIRST) begin : g_src_s1
            assign lv_gi[l] = s1.g;
            assign lv_pi[l] = s1.p;
            assign lv_ci[l] = s1.cin;
        end else if (l == S3_FIRST) begin : g_src_s2
            assign lv_gi[l] = s2.g;
            assign lv_pi[l] = s2.p;
            assign lv_ci[l] = s2.cin;
        end else begin : g_src_prev
            assign lv_gi[l] = lv_go[l-1];
            assign lv_pi[l] = lv_po[l-1];
            assign lv_ci[l] = lv_ci[l-1];
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (KS_SPAN[l])
        ) u_level (
            .G_IN  (lv_gi[l]),
            .P_IN  (lv_pi[l]),
            .CIN   (lv_ci[l]),
            .G_OUT (lv_go[l]),
            .P_OUT (lv_po[l])
        );
    end

    always_comb begin
        gpre   = lv_go[KS_LEVELS-1];
        sum_d  = s2.p0 ^ {gpre[WIDTH-2:0], s2.cin};
        cout_d = gpre[WIDTH-1];
        ovf_d  = gpre[WIDTH-1] ^ gpre[WIDTH-2];
        zero_d = (sum_d == '0);
    end

    assign adv3     = !OUT_VALID | OUT_READY;
    assign adv2     = !s2.valid | adv3;
    assign adv1     = !s1.valid | adv2;
    assign IN_READY = adv1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1        <= '0;
            s2        <= '0;
            OUT_VALID <= 1'b0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
            ZERO      <= 1'b0;
        end else begin
            if (adv1) begin
                s1.valid <= IN_VALID;
                if (IN_VALID) begin
                    s1.g   <= lv_go[S2_FIRST-1];
                    s1.p   <= lv_po[S2_FIRST-1];
                    s1.p0  <= lv_pi[0];
                    s1.cin <= SUB;
                end
            end
            if (adv2) begin
                s2.valid <= s1.valid;
                if (s1.valid) begin
                    s2.g   <= lv_go[S3_FIRST-1];
                    s2.p   <= lv_po[S3_FIRST-1];
                    s2.p0  <= s1.p0;
                    s2.cin <= s1.cin;
                end
            end
            if (adv3) begin
                OUT_VALID <= s2.valid;
                if (s2.valid) begin
                    SUM  <= sum_d;
                    COUT <= cout_d;
                    OVF  <= ovf_d;
                    ZERO <= zero_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_ks28_pipe_addsub.sv
// Scoreboard bench for ks28_pipe_addsub: directed corners, backpressure,
// mid-flight reset and a long random valid/ready run.
module tb_ks28_pipe_addsub;

    localparam int unsigned W = 28;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         CLK       = 1'b0;
    logic         RST_N     = 1'b1;
    logic         IN_VALID  = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         SUB       = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;
    logic         ZERO;

    int total   = 0;
    int bad     = 0;
    int acc_cnt = 0;
    int del_cnt = 0;

    exp_t sb[$];
    logic held = 1'b0;
    exp_t held_v;

    ks28_pipe_addsub #(
        .WIDTH (W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF),
        .ZERO      (ZERO)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   full;
        bx     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, s};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bx[W-1]) && (e.sum[W-1] != a[W-1]);
        e.zero = (e.sum == '0);
        return e;
    endfunction

    // Handshakes are decided by values stable from mid-cycle up to the next rising edge
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST_N) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (OUT_VALID !== 1'b1 || {SUM, COUT, OVF, ZERO} !== {held_v.sum, held_v.cout, held_v.ovf, held_v.zero}) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%0b sum=%h c=%0b o=%0b z=%0b want v=1 sum=%h c=%0b o=%0b z=%0b",
                             OUT_VALID, SUM, COUT, OVF, ZERO, held_v.sum, held_v.cout, held_v.ovf, held_v.zero);
                end
            end
            held          = OUT_VALID && !OUT_READY;
            held_v.sum    = SUM;
            held_v.cout   = COUT;
            held_v.ovf    = OVF;
            held_v.zero   = ZERO;
            if (OUT_VALID && OUT_READY) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got output sum=%h want none pending", SUM);
                end else begin
                    e = sb.pop_front();
                    del_cnt++;
                    if ({SUM, COUT, OVF, ZERO} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                        bad++;
                        $display("FAIL sb_result: got sum=%h c=%0b o=%0b z=%0b want sum=%h c=%0b o=%0b z=%0b",
                                 SUM, COUT, OVF, ZERO, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
            end
            if (IN_VALID && IN_READY) begin
                sb.push_back(model(A, B, SUB));
                acc_cnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        A        = a;
        B        = b;
        SUB      = s;
        IN_VALID = 1'b1;
    endtask

    // Issue one op into an empty pipe and count edges until OUT_VALID shows up
    task automatic send_timed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              output int edges, output exp_t got);
        put(a, b, s);
        @(negedge CLK);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        edges = 1;
        while (edges < 10) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) break;
            @(posedge CLK);
            edges++;
        end
        got.sum  = SUM;
        got.cout = COUT;
        got.ovf  = OVF;
        got.zero = ZERO;
        cyc();
    endtask

    task automatic wait_out(output exp_t got, output bit ok);
        ok = 1'b0;
        for (int unsigned n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) begin
                ok       = 1'b1;
                got.sum  = SUM;
                got.cout = COUT;
                got.ovf  = OVF;
                got.zero = ZERO;
                break;
            end
        end
        cyc();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %0b want 0", OUT_VALID);
        end
        total++;
        if ({SUM, COUT, OVF, ZERO} !== {{W{1'b0}}, 3'b000}) begin
            bad++;
            $display("FAIL reset_outputs: got sum=%h c=%0b o=%0b z=%0b want all 0", SUM, COUT, OVF, ZERO);
        end
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %0b want 1", IN_READY);
        end
    endtask

    task automatic test_add_wrap();
        int   edges;
        exp_t got;
        cyc();
        OUT_READY = 1'b1;
        send_timed(28'hFFFFFFF, 28'h0000001, 1'b0, edges, got);
        total++;
        if (edges !== 3) begin
            bad++;
            $display("FAIL add_latency: got %0d edges want 3", edges);
        end
        total++;
        if ({got.sum, got.cout, got.zero, got.ovf} !== {28'h0000000, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_wrap: got sum=%h c=%0b z=%0b o=%0b want sum=0000000 c=1 z=1 o=0",
                     got.sum, got.cout, got.zero, got.ovf);
        end
    endtask

    task automatic test_sub_ovf();
        logic [W-1:0] ta [3] = '{28'h0000005, 28'h7FFFFFF, 28'h1234567};
        logic [W-1:0] tb [3] = '{28'h0000007, 28'h0000001, 28'h1234567};
        logic         ts [3] = '{1'b1, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{28'hFFFFFFE, 28'h8000000, 28'h0000000};
        logic [2:0]   ef [3] = '{3'b000, 3'b010, 3'b101};
        exp_t got;
        bit   ok;
        for (int unsigned i = 0; i < 3; i++) begin
            put(ta[i], tb[i], ts[i]);
            cyc();
            IN_VALID = 1'b0;
            wait_out(got, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL sub_timeout: case %0d got no OUT_VALID want one within 10 cycles", i);
            end
            total++;
            if ({got.sum, got.cout, got.ovf, got.zero} !== {es[i], ef[i]}) begin
                bad++;
                $display("FAIL sub_case%0d: got sum=%h {c,o,z}=%b want sum=%h {c,o,z}=%b",
                         i, got.sum, {got.cout, got.ovf, got.zero}, es[i], ef[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] oa [6];
        logic [W-1:0] ob [6];
        logic         os [6];
        logic [W-1:0] hold_sum;
        exp_t         first;
        int           k;
        int           cnt;
        logic         r;
        for (int unsigned i = 0; i < 6; i++) begin
            oa[i] = W'($urandom);
            ob[i] = W'($urandom);
            os[i] = 1'($urandom_range(0, 1));
        end
        first     = model(oa[0], ob[0], os[0]);
        OUT_READY = 1'b0;
        k         = 0;
        put(oa[0], ob[0], os[0]);
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge CLK);
            r = IN_READY;
            cyc();
            if (r) begin
                k++;
                put(oa[k], ob[k], os[k]);
            end
        end
        total++;
        if (k !== 3) begin
            bad++;
            $display("FAIL bp_accepted: got %0d want 3", k);
        end
        @(negedge CLK);
        total++;
        if (IN_READY !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready: got %0b want 0", IN_READY);
        end
        hold_sum = SUM;
        cyc();
        cyc();
        @(negedge CLK);
        total++;
        if (OUT_VALID !== 1'b1 || SUM !== hold_sum || SUM !== first.sum) begin
            bad++;
            $display("FAIL bp_hold: got v=%0b sum=%h want v=1 sum=%h", OUT_VALID, SUM, first.sum);
        end
        cyc();
        OUT_READY = 1'b1;
        cnt       = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (OUT_VALID) cnt++;
            r = IN_READY && IN_VALID;
            cyc();
            if (r) begin
                k++;
                if (k < 6) put(oa[k], ob[k], os[k]);
                else IN_VALID = 1'b0;
            end
        end
        total++;
        if (cnt !== 6 || k !== 6) begin
            bad++;
            $display("FAIL bp_drain: got %0d outputs %0d accepted want 6 and 6", cnt, k);
        end
        IN_VALID = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset_midflight();
        int   edges;
        exp_t got;
        bit   stale;
        OUT_READY = 1'b0;
        put(28'h0ABCDEF, 28'h0123456, 1'b0);
        cyc();
        put(28'h0000010, 28'h0000020, 1'b1);
        cyc();
        IN_VALID = 1'b0;
        cyc();
        cyc();
        total++;
        if (OUT_VALID !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_valid: got %0b want 1", OUT_VALID);
        end
        #2 RST_N = 1'b0;
        sb.delete();
        #1;
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL rst_async_drop: got %0b want 0", OUT_VALID);
        end
        @(posedge CLK);
        #3 RST_N  = 1'b1;
        OUT_READY = 1'b1;
        stale     = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL rst_stale: got OUT_VALID=1 after reset want 0");
        end
        cyc();
        send_timed(28'h0000003, 28'h0000004, 1'b0, edges, got);
        total++;
        if (edges !== 3 || got.sum !== 28'h0000007) begin
            bad++;
            $display("FAIL rst_new_op: got %0d edges sum=%h want 3 edges sum=0000007", edges, got.sum);
        end
    endtask

    task automatic test_back_to_back();
        int hs;
        OUT_READY = 1'b1;
        hs        = 0;
        for (int unsigned c = 0; c < 20; c++) begin
            put(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            @(negedge CLK);
            if (IN_READY === 1'b1) hs++;
            cyc();
        end
        IN_VALID = 1'b0;
        total++;
        if (hs !== 20) begin
            bad++;
            $display("FAIL b2b_throughput: got %0d accepts want 20", hs);
        end
        repeat (5) cyc();
    endtask

    task automatic test_random();
        int acc_base;
        int del_base;
        int cycles;
        acc_base = acc_cnt;
        del_base = del_cnt;
        cycles   = 0;
        while ((acc_cnt - acc_base) < 10000 && cycles < 60000) begin
            IN_VALID  = ($urandom_range(0, 9) < 7);
            A         = W'($urandom);
            B         = ($urandom_range(0, 15) == 0) ? A : W'($urandom);
            SUB       = 1'($urandom_range(0, 1));
            OUT_READY = ($urandom_range(0, 9) < 7);
            cyc();
            cycles++;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int unsigned c = 0; c < 20 && sb.size() != 0; c++) cyc();
        total++;
        if ((acc_cnt - acc_base) < 10000) begin
            bad++;
            $display("FAIL rand_accept_timeout: got %0d accepted want 10000", acc_cnt - acc_base);
        end
        total++;
        if (sb.size() != 0 || (acc_cnt - acc_base) !== (del_cnt - del_base)) begin
            bad++;
            $display("FAIL rand_count: got %0d delivered %0d pending want %0d delivered 0 pending",
                     del_cnt - del_base, sb.size(), acc_cnt - acc_base);
        end
    endtask

    initial begin
        #2 RST_N = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub_ovf();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running want finished before 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
